// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the RV_CPU run-control sequencer.
// Contents: the state encoding, default reset-hold and idle-timeout values,
// and the width of the single-step counter.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RST_HOLD = 2'd0,
      ST_RUN      = 2'd1,
      ST_HALTED   = 2'd2,
      ST_STEP     = 2'd3
   } cpu_state_e;

   localparam int unsigned DEF_RST_HOLD     = 4;
   localparam int unsigned DEF_IDLE_TIMEOUT = 16;
   localparam int unsigned STEP_CNT_W       = 8;

endpackage

// File: rtl/cpu_ctrl_sat_counter.sv
// Saturating up-counter. It counts cycles with en_i=1 and holds at all-ones.
// Ports:
//   clk     - clock
//   reset   - synchronous active-high clear
//   en_i    - count enable
//   count_o - registered count value
module cpu_ctrl_sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (en_i && (count_q != '1)) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/cpu_clk_gate_ctrl.sv
// Run-control sequencer for the RV_CPU core: stretches core reset, then
// arbitrates run / halt / step requests and drives the clk_gate enable.
// Optional idle auto-halt is built when CPU_IDLE_GATE_EN is defined.
// Ports:
//   clk, reset             - ungated clock, synchronous active-high reset
//   run_req, step_req      - requests honoured in HALTED (step has priority)
//   halt_req               - request honoured in RUN and STEP (highest priority)
//   step_count             - number of core cycles for a step, taken with step_req
//   cpu_out                - core output bus, watched for idle detection
//   cpu_reset, clk_en      - core reset and clk_gate enable
//   halted, step_done      - HALTED status, one-cycle step completion pulse
//   idle_halt              - sticky: the last halt came from idle detection
//   run_cycles             - saturating count of gated, out-of-reset cycles
module cpu_clk_gate_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned RST_HOLD     = DEF_RST_HOLD,
   parameter int unsigned AUTO_RUN     = 1,
   parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run_req,
   input  logic                  halt_req,
   input  logic                  step_req,
   input  logic [STEP_CNT_W-1:0] step_count,
   input  logic [9:0]            cpu_out,
   output logic                  cpu_reset,
   output logic                  clk_en,
   output logic                  halted,
   output logic                  step_done,
   output logic                  idle_halt,
   output logic [CNT_W-1:0]      run_cycles
);

   localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   cpu_state_e            state_q, state_d;
   logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
   logic                  cpu_reset_q, cpu_reset_d;
   logic                  clk_en_q, clk_en_d;
   logic                  halted_q, halted_d;
   logic                  step_done_q, step_done_d;

`ifdef CPU_IDLE_GATE_EN
   localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [9:0]        cpu_out_q;
   logic              idle_halt_q, idle_halt_d;
`endif

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RST_HOLD;
         hold_cnt_q  <= '0;
         step_cnt_q  <= '0;
         cpu_reset_q <= 1'b1;
         clk_en_q    <= 1'b1;
         halted_q    <= 1'b0;
         step_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         step_cnt_q  <= step_cnt_d;
         cpu_reset_q <= cpu_reset_d;
         clk_en_q    <= clk_en_d;
         halted_q    <= halted_d;
         step_done_q <= step_done_d;
      end
   end

`ifdef CPU_IDLE_GATE_EN
   // Idle tracking registers
   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt_q  <= '0;
         cpu_out_q   <= '0;
         idle_halt_q <= 1'b0;
      end else begin
         idle_cnt_q  <= idle_cnt_d;
         cpu_out_q   <= cpu_out;
         idle_halt_q <= idle_halt_d;
      end
   end
`endif

   // Next-state and output decode
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      step_cnt_d  = step_cnt_q;
      step_done_d = 1'b0;
`ifdef CPU_IDLE_GATE_EN
      // Counter only runs in RUN, so every entry to RUN starts from zero
      idle_cnt_d  = '0;
      idle_halt_d = idle_halt_q;
`endif

      case (state_q)
         ST_RST_HOLD: begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
               hold_cnt_d = '0;
               state_d    = (AUTO_RUN != 0) ? ST_RUN : ST_HALTED;
            end
         end
         ST_RUN: begin
`ifdef CPU_IDLE_GATE_EN
            if (cpu_out == cpu_out_q) begin
               idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
`endif
            if (halt_req) begin
               state_d = ST_HALTED;
`ifdef CPU_IDLE_GATE_EN
            end else if (idle_cnt_d == IDLE_W'(IDLE_TIMEOUT)) begin
               state_d     = ST_HALTED;
               idle_halt_d = 1'b1;
`endif
            end
         end
         ST_HALTED: begin
            // A zero-length step is dropped and does not block run_req
            if (step_req && (step_count != '0)) begin
               state_d    = ST_STEP;
               step_cnt_d = step_count;
            end else if (run_req) begin
               state_d = ST_RUN;
`ifdef CPU_IDLE_GATE_EN
               idle_halt_d = 1'b0;
`endif
            end
         end
         ST_STEP: begin
            if (halt_req) begin
               state_d    = ST_HALTED;
               step_cnt_d = '0;
            end else if (step_cnt_q == STEP_CNT_W'(1)) begin
               state_d     = ST_HALTED;
               step_cnt_d  = '0;
               step_done_d = 1'b1;
            end else begin
               step_cnt_d = step_cnt_q - STEP_CNT_W'(1);
            end
         end
      endcase

      // Outputs follow the next state so they change exactly on the transition edge
      cpu_reset_d = (state_d == ST_RST_HOLD);
      clk_en_d    = (state_d != ST_HALTED);
      halted_d    = (state_d == ST_HALTED);
   end

   cpu_ctrl_sat_counter #(
      .W(CNT_W)
   ) u_run_cnt (
      .clk     (clk),
      .reset   (reset),
      .en_i    (clk_en_q & ~cpu_reset_q),
      .count_o (run_cycles)
   );

   assign cpu_reset = cpu_reset_q;
   assign clk_en    = clk_en_q;
   assign halted    = halted_q;
   assign step_done = step_done_q;

`ifdef CPU_IDLE_GATE_EN
   assign idle_halt = idle_halt_q;
`else
   logic unused_idle_inputs;
   assign unused_idle_inputs = ^{cpu_out, IDLE_TIMEOUT[0]};
   assign idle_halt          = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_clk_gate_ctrl.sv
// Scoreboard bench for cpu_clk_gate_ctrl: each scenario queues the expected
// per-cycle outputs as it drives stimulus, then pops and compares one entry
// per clock. A second small-counter instance covers run_cycles saturation.
module tb_cpu_clk_gate_ctrl;

   typedef struct packed {
      logic        cpu_reset;
      logic        clk_en;
      logic        halted;
      logic        step_done;
      logic        idle_halt;
      logic [31:0] run_cycles;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset, run_req, halt_req, step_req;
   logic [7:0]  step_count;
   logic [9:0]  cpu_out;
   logic        cpu_reset, clk_en, halted, step_done, idle_halt;
   logic [31:0] run_cycles;

   logic        sat_unused_rst, sat_unused_en, sat_unused_hlt, sat_unused_done, sat_unused_idle;
   logic [3:0]  sat_run_cycles;

   obs_t        sb[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   int unsigned rc     = 0;
   bit          hold_out = 1'b0;

   always #5 clk = ~clk;

   cpu_clk_gate_ctrl #(
      .RST_HOLD(4), .AUTO_RUN(1), .IDLE_TIMEOUT(16), .CNT_W(32)
   ) dut (
      .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req),
      .step_req(step_req), .step_count(step_count), .cpu_out(cpu_out),
      .cpu_reset(cpu_reset), .clk_en(clk_en), .halted(halted),
      .step_done(step_done), .idle_halt(idle_halt), .run_cycles(run_cycles)
   );

   cpu_clk_gate_ctrl #(
      .RST_HOLD(1), .AUTO_RUN(1), .IDLE_TIMEOUT(16), .CNT_W(4)
   ) dut_sat (
      .clk(clk), .reset(reset), .run_req(1'b0), .halt_req(1'b0),
      .step_req(1'b0), .step_count(8'd0), .cpu_out(cpu_out),
      .cpu_reset(sat_unused_rst), .clk_en(sat_unused_en), .halted(sat_unused_hlt),
      .step_done(sat_unused_done), .idle_halt(sat_unused_idle), .run_cycles(sat_run_cycles)
   );

   function automatic obs_t mk(logic r, logic e, logic h, logic d, int unsigned c);
      return {r, e, h, d, 1'b0, 32'(c)};
   endfunction

   function automatic obs_t sample();
      return {cpu_reset, clk_en, halted, step_done, idle_halt, run_cycles};
   endfunction

   function automatic string fmt(obs_t v);
      return $sformatf("rst=%b en=%b hlt=%b done=%b idle=%b rc=%0d",
                       v.cpu_reset, v.clk_en, v.halted, v.step_done, v.idle_halt, v.run_cycles);
   endfunction

   task automatic push_n(obs_t e, int n);
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   // One clock; request pulses last exactly one sampled edge
   task automatic tick();
      @(posedge clk);
      #1;
      run_req  = 1'b0;
      halt_req = 1'b0;
      step_req = 1'b0;
      if (!hold_out) cpu_out = cpu_out + 10'd1;
   endtask

   task automatic test_reset();
      obs_t o, e;
      reset = 1'b1;
      push_n(mk(1, 1, 0, 0, 0), 3);
      while (sb.size() != 0) begin
         tick(); o = sample(); e = sb.pop_front(); n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL reset_held: got %s want %s", fmt(o), fmt(e)); end
      end
      reset = 1'b0;
      push_n(mk(1, 1, 0, 0, 0), 3);
      sb.push_back(mk(0, 1, 0, 0, 0));
      while (sb.size() != 0) begin
         tick(); o = sample(); e = sb.pop_front(); n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL reset_hold: got %s want %s", fmt(o), fmt(e)); end
      end
      rc = 0;
   endtask

   task automatic test_run_count();
      obs_t o, e;
      for (int i = 1; i <= 10; i++) sb.push_back(mk(0, 1, 0, 0, i));
      while (sb.size() != 0) begin
         tick(); o = sample(); e = sb.pop_front(); n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL run_count: got %s want %s", fmt(o), fmt(e)); end
      end
      rc = 10;
   endtask

   task automatic test_halt();
      obs_t o, e;
      halt_req = 1'b1;
      rc = rc + 1;
      push_n(mk(0, 0, 1, 0, rc), 4);
      while (sb.size() != 0) begin
         tick(); o = sample(); e = sb.pop_front(); n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL halt: got %s want %s", fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_step();
      obs_t o, e;
      step_count = 8'd5;
      step_req   = 1'b1;
      for (int i = 0; i < 5; i++) sb.push_back(mk(0, 1, 0, 0, rc + i));
      rc = rc + 5;
      sb.push_back(mk(0, 0, 1, 1, rc));
      push_n(mk(0, 0, 1, 0, rc), 2);
      while (sb.size() != 0) begin
         tick(); o = sample(); e = sb.pop_front(); n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL step5: got %s want %s", fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_step_zero();
      obs_t o, e;
      step_count = 8'd0;
      step_req   = 1'b1;
      push_n(mk(0, 0, 1, 0, rc), 4);
      while (sb.size() != 0) begin
         tick(); o = sample(); e = sb.pop_front(); n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL step0: got %s want %s", fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_step_run_same();
      obs_t o, e;
      step_count = 8'd3;
      step_req   = 1'b1;
      run_req    = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back(mk(0, 1, 0, 0, rc + i));
      rc = rc + 3;
      sb.push_back(mk(0, 0, 1, 1, rc));
      push_n(mk(0, 0, 1, 0, rc), 3);
      while (sb.size() != 0) begin
         tick(); o = sample(); e = sb.pop_front(); n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL step_vs_run: got %s want %s", fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_step_abort();
      obs_t o, e;
      step_count = 8'd20;
      step_req   = 1'b1;
      for (int i = 0; i < 5; i++) sb.push_back(mk(0, 1, 0, 0, rc + i));
      while (sb.size() != 0) begin
         tick(); o = sample(); e = sb.pop_front(); n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL step_abort_run: got %s want %s", fmt(o), fmt(e)); end
      end
      halt_req = 1'b1;
      rc = rc + 5;
      push_n(mk(0, 0, 1, 0, rc), 4);
      while (sb.size() != 0) begin
         tick(); o = sample(); e = sb.pop_front(); n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL step_abort_halt: got %s want %s", fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_reset_mid_run();
      obs_t o, e;
      run_req = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back(mk(0, 1, 0, 0, rc + i));
      while (sb.size() != 0) begin
         tick(); o = sample(); e = sb.pop_front(); n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL run_again: got %s want %s", fmt(o), fmt(e)); end
      end
      reset = 1'b1;
      sb.push_back(mk(1, 1, 0, 0, 0));
      while (sb.size() != 0) begin
         tick(); o = sample(); e = sb.pop_front(); n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL reset_mid_run: got %s want %s", fmt(o), fmt(e)); end
      end
      reset = 1'b0;
      push_n(mk(1, 1, 0, 0, 0), 3);
      sb.push_back(mk(0, 1, 0, 0, 0));
      sb.push_back(mk(0, 1, 0, 0, 1));
      while (sb.size() != 0) begin
         tick(); o = sample(); e = sb.pop_front(); n_chk++;
         if (o !== e) begin n_fail++; $display("FAIL rehold: got %s want %s", fmt(o), fmt(e)); end
      end
      rc = 1;
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) tick();
      rc = rc + 20;
      n_chk++;
      if (sat_run_cycles !== 4'hF) begin
         n_fail++; $display("FAIL sat_reach: got %0d want 15", sat_run_cycles);
      end
      n_chk++;
      if (run_cycles !== 32'(rc)) begin
         n_fail++; $display("FAIL long_run: got %0d want %0d", run_cycles, rc);
      end
      for (int i = 0; i < 5; i++) tick();
      rc = rc + 5;
      n_chk++;
      if (sat_run_cycles !== 4'hF) begin
         n_fail++; $display("FAIL sat_hold: got %0d want 15", sat_run_cycles);
      end
   endtask

`ifdef CPU_IDLE_GATE_EN
   task automatic test_idle();
      int n;
      n = 0;
      hold_out = 1'b1;
      while (!halted && n < 40) begin
         tick();
         n++;
      end
      n_chk++;
      if (n != 17) begin n_fail++; $display("FAIL idle_latency: got %0d cycles want 17", n); end
      n_chk++;
      if (idle_halt !== 1'b1) begin n_fail++; $display("FAIL idle_set: got %b want 1", idle_halt); end
      hold_out = 1'b0;
      run_req  = 1'b1;
      tick();
      n_chk++;
      if ({idle_halt, halted, clk_en} !== 3'b001) begin
         n_fail++; $display("FAIL idle_clear: got idle=%b hlt=%b en=%b want 0 0 1", idle_halt, halted, clk_en);
      end
   endtask
`endif

   initial begin
      reset      = 1'b1;
      run_req    = 1'b0;
      halt_req   = 1'b0;
      step_req   = 1'b0;
      step_count = 8'd0;
      cpu_out    = 10'd0;
      test_reset();
      test_run_count();
      test_halt();
      test_step();
      test_step_zero();
      test_step_run_same();
      test_step_abort();
      test_reset_mid_run();
      test_saturation();
`ifdef CPU_IDLE_GATE_EN
      test_idle();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
